mips_run_ctrl: RTL and testbench
================================

MIPS_RUN_CTRL -- requirements
Module: mips_run_ctrl

Interface
REQ-001 Parameter PC_W, default 32, width of the PC compare path.
REQ-002 Parameter CNT_W, default 32, width of the cycle counter.
REQ-003 Parameter RST_CYCLES, default 4, number of cycles core_reset is held after start; legal range 1..255.
REQ-004 Parameter HALT_STABLE, default 8, number of consecutive identical-PC enabled cycles that mean "halted"; legal range 1..255.
REQ-005 Parameter TIMEOUT, default 100000, maximum number of enabled core cycles per run; must be less than 2^CNT_W.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset of this block.
REQ-008 start  input  1  one-cycle pulse that begins or restarts a run.
REQ-009 step_mode  input  1  1 selects single-step operation; 0 selects free run.
REQ-010 step  input  1  in single-step operation, a one-cycle pulse advancing the core one cycle.
REQ-011 pc  input  PC_W  current PC of the controlled core.
REQ-012 halt_pc  input  PC_W  PC value that terminates the run.
REQ-013 core_reset  output  1  active-high synchronous reset to the core.
REQ-014 core_en  output  1  clock enable to the core.
REQ-015 busy  output  1  high in RESET, RUN and STEP_WAIT.
REQ-016 done  output  1  level; high while in DONE.
REQ-017 timeout  output  1  level; high in DONE when the run ended by timeout.
REQ-018 cycle_cnt  output  CNT_W  number of enabled core cycles in the current or last run.

Function
REQ-019 The FSM SHALL have exactly five states: IDLE, RESET, RUN, STEP_WAIT and DONE.
REQ-020 In IDLE: core_reset=1 and core_en=0; start SHALL cause a transition to RESET.
REQ-021 On entry to RESET: load the hold counter to RST_CYCLES, clear cycle_cnt, clear timeout and clear the PC-stable tracking.
REQ-022 In RESET: core_reset=1 and core_en=0 for exactly RST_CYCLES cycles.
REQ-023 After RESET, the FSM SHALL go to RUN if step_mode=0 or to STEP_WAIT if step_mode=1.
REQ-024 In RUN: core_reset=0 and core_en=1 every cycle.
REQ-025 In RUN, step_mode=1 SHALL cause a transition to STEP_WAIT on the next edge.
REQ-026 In STEP_WAIT: core_reset=0; core_en is combinational and equals step.
REQ-027 In STEP_WAIT, step_mode=0 SHALL cause a transition to RUN.
REQ-028 An "enabled cycle" is any cycle with core_en=1; halt checks and counting SHALL occur only in enabled cycles.
REQ-029 cycle_cnt SHALL increment by 1 on each enabled cycle, including the cycle that halts the run.
REQ-030 Halt condition A: pc == halt_pc in an enabled cycle.
REQ-031 Halt condition B: the stable counter reaches HALT_STABLE.
  - Each enabled cycle registers pc as prev_pc and sets a valid flag.
  - The stable counter increments when valid=1 and pc == prev_pc; it clears otherwise.
REQ-032 Halt condition C: cycle_cnt reaches TIMEOUT (post-increment value) in an enabled cycle.
REQ-033 Any of conditions A, B or C SHALL cause a transition to DONE on the same edge.
REQ-034 timeout SHALL be set to 1 only when C holds and neither A nor B holds in that cycle.
REQ-035 In DONE: core_en=0 and core_reset=0, so core state is preserved for inspection; cycle_cnt SHALL be held.
REQ-036 In DONE, start SHALL cause a transition to RESET (restart).
REQ-037 start SHALL be ignored in RESET, RUN and STEP_WAIT.
REQ-038 step SHALL be ignored outside STEP_WAIT.

Reset
REQ-039 Asserting reset (low) at any time SHALL immediately force state=IDLE, core_reset=1, core_en=0, busy=0, done=0, timeout=0, cycle_cnt=0, prev_pc valid=0 and stable count=0.
REQ-040 After reset deasserts, the block SHALL stay in IDLE until start.

Verification (RST_CYCLES=4, HALT_STABLE=8, TIMEOUT=100)
REQ-041 Pulse start with step_mode=0, pc=0x3000 advancing by 4 per enabled cycle, halt_pc=0x3010 -> core_reset high for 4 cycles, then done=1 with cycle_cnt=5 and timeout=0.
REQ-042 Same setup but pc held at 0x3008 -> done=1 after 9 enabled cycles, cycle_cnt=9, timeout=0.
REQ-043 pc incrementing and halt_pc=0xFFFFFFFC -> done=1 with timeout=1 and cycle_cnt=100; core_en low from the next cycle onward.
REQ-044 step_mode=1 with 3 step pulses spaced 5 cycles apart -> core_en high for exactly 3 cycles, cycle_cnt=3, busy=1, done=0.
REQ-045 Drive reset low mid-RUN at cycle_cnt=20 -> all outputs take reset values within the same cycle; a start pulse during RUN changes nothing.
REQ-046 From DONE, pulse start -> cycle_cnt clears to 0, timeout clears, core_reset is high for 4 cycles, then the run repeats with identical results.

Source files
------------

// File: rtl/mips_run_ctrl_if.sv
// ----------------------------------------------------------------------------
// mips_run_ctrl_if
// Bundles the control/observation signals between a run controller and the
// environment that owns the core (host side).
//
// Handshake semantics: start and step are single-cycle pulses sampled on the
// rising clock edge; there is no ready/ack. Outputs are levels, except
// core_en, which follows step combinationally while single-stepping.
//
// Signals (host view):
//   start      host -> ctrl  pulse, begin/restart a run
//   step_mode  host -> ctrl  1 = single-step, 0 = free run
//   step       host -> ctrl  pulse, advance one cycle in single-step
//   pc         core -> ctrl  current PC of the controlled core
//   halt_pc    host -> ctrl  PC that terminates the run
//   core_reset ctrl -> core  active-high synchronous core reset
//   core_en    ctrl -> core  core clock enable
//   busy       ctrl -> host  high in RESET, RUN, STEP_WAIT
//   done       ctrl -> host  high in DONE
//   timeout    ctrl -> host  run ended by cycle limit
//   cycle_cnt  ctrl -> host  enabled core cycles in current/last run
//   dbg_state  ctrl -> host  encoded FSM state for observation
// ----------------------------------------------------------------------------
interface mips_run_ctrl_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
);
    logic             start;
    logic             step_mode;
    logic             step;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  halt_pc;
    logic             core_reset;
    logic             core_en;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] cycle_cnt;
    logic [2:0]       dbg_state;

    modport master (
        output start, step_mode, step, pc, halt_pc,
        input  core_reset, core_en, busy, done, timeout, cycle_cnt, dbg_state
    );

    modport slave (
        input  start, step_mode, step, pc, halt_pc,
        output core_reset, core_en, busy, done, timeout, cycle_cnt, dbg_state
    );
endinterface

// File: rtl/mips_run_ctrl.sv
// ----------------------------------------------------------------------------
// mips_run_ctrl
// Run controller for a MIPS core: holds the core in reset after start, then
// lets it run freely or single-step, and stops it when the PC hits halt_pc,
// the PC stays unchanged for HALT_STABLE enabled cycles, or TIMEOUT enabled
// cycles have elapsed. In DONE the core is frozen (no reset, no enable) so
// its state can be inspected.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset of this block
//   bus    mips_run_ctrl_if.slave (start/step inputs, pc compare inputs,
//          core_reset/core_en/status outputs, dbg_state)
// ----------------------------------------------------------------------------
module mips_run_ctrl #(
    parameter int PC_W        = 32,
    parameter int CNT_W       = 32,
    parameter int RST_CYCLES  = 4,
    parameter int HALT_STABLE = 8,
    parameter int TIMEOUT     = 100000
) (
    input  logic           clk,
    input  logic           reset,
    mips_run_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RESET     = 3'd1,
        S_RUN       = 3'd2,
        S_STEP_WAIT = 3'd3,
        S_DONE      = 3'd4
    } state_e;

    localparam logic [7:0]       RST_C    = 8'(RST_CYCLES);
    localparam logic [7:0]       STABLE_C = 8'(HALT_STABLE);
    localparam logic [CNT_W-1:0] LIMIT_C  = CNT_W'(TIMEOUT);

    state_e           state_q, state_d;
    logic [7:0]       hold_q, hold_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic [PC_W-1:0]  prev_pc_q, prev_pc_d;
    logic             prev_valid_q, prev_valid_d;
    logic [7:0]       stable_q, stable_d;

    logic             core_reset;
    logic             core_en;
    logic             busy;
    logic             done;
    logic             enter_reset;
    logic [CNT_W-1:0] cnt_inc;
    logic [7:0]       stable_inc;
    logic             hit_a, hit_b, hit_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            hold_q       <= '0;
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
            prev_pc_q    <= '0;
            prev_valid_q <= 1'b0;
            stable_q     <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            cnt_q        <= cnt_d;
            timeout_q    <= timeout_d;
            prev_pc_q    <= prev_pc_d;
            prev_valid_q <= prev_valid_d;
            stable_q     <= stable_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        cnt_d        = cnt_q;
        timeout_d    = timeout_q;
        prev_pc_d    = prev_pc_q;
        prev_valid_d = prev_valid_q;
        stable_d     = stable_q;
        core_reset   = 1'b0;
        core_en      = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        enter_reset  = 1'b0;

        // Candidate updates for an enabled cycle; committed only when core_en.
        cnt_inc    = cnt_q + 1'b1;
        stable_inc = (prev_valid_q && (bus.pc == prev_pc_q)) ? stable_q + 1'b1 : 8'd0;
        hit_a      = (bus.pc == bus.halt_pc);
        hit_b      = (stable_inc == STABLE_C);
        hit_c      = (cnt_inc == LIMIT_C);

        unique case (state_q)
            S_IDLE: begin
                core_reset = 1'b1;
                if (bus.start) enter_reset = 1'b1;
            end
            S_RESET: begin
                core_reset = 1'b1;
                busy       = 1'b1;
                // hold_q was loaded with RST_CYCLES on entry, so leaving when
                // it reads 1 gives exactly RST_CYCLES cycles in this state.
                if (hold_q <= 8'd1) begin
                    state_d = bus.step_mode ? S_STEP_WAIT : S_RUN;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            S_RUN: begin
                busy    = 1'b1;
                core_en = 1'b1;
                if (bus.step_mode) state_d = S_STEP_WAIT;
            end
            S_STEP_WAIT: begin
                busy    = 1'b1;
                core_en = bus.step;
                if (!bus.step_mode) state_d = S_RUN;
            end
            S_DONE: begin
                done = 1'b1;
                if (bus.start) enter_reset = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (core_en) begin
            cnt_d        = cnt_inc;
            prev_pc_d    = bus.pc;
            prev_valid_d = 1'b1;
            stable_d     = stable_inc;
            // Halting overrides any step_mode change requested this cycle.
            if (hit_a || hit_b || hit_c) begin
                state_d   = S_DONE;
                timeout_d = hit_c && !hit_a && !hit_b;
            end
        end

        if (enter_reset) begin
            state_d      = S_RESET;
            hold_d       = RST_C;
            cnt_d        = '0;
            timeout_d    = 1'b0;
            prev_valid_d = 1'b0;
            stable_d     = '0;
        end
    end

    assign bus.core_reset = core_reset;
    assign bus.core_en    = core_en;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.timeout    = timeout_q;
    assign bus.cycle_cnt  = cnt_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mips_run_ctrl
// Directed bench for mips_run_ctrl (RST_CYCLES=4, HALT_STABLE=8, TIMEOUT=100).
// A small core model advances pc on enabled cycles; each run pushes its
// expected {timeout, cycle_cnt} into exp_q and a monitor pops it when done
// rises.
// ----------------------------------------------------------------------------
module tb_mips_run_ctrl;
    localparam int PC_W        = 32;
    localparam int CNT_W       = 32;
    localparam int RST_CYCLES  = 4;
    localparam int HALT_STABLE = 8;
    localparam int TIMEOUT     = 100;

    logic clk;
    logic rst_n;

    mips_run_ctrl_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    mips_run_ctrl #(
        .PC_W(PC_W), .CNT_W(CNT_W), .RST_CYCLES(RST_CYCLES),
        .HALT_STABLE(HALT_STABLE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [CNT_W:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    int en_cnt  = 0;
    int rst_cnt = 0;
    logic done_seen = 1'b0;

    logic [PC_W-1:0] pc_base = 32'h3000;
    logic [PC_W-1:0] pc_inc  = 32'd4;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- core model ----------------
    initial begin
        bus.pc = 32'h3000;
        forever begin
            @(posedge clk);
            if (bus.core_reset)   bus.pc <= pc_base;
            else if (bus.core_en) bus.pc <= bus.pc + pc_inc;
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [CNT_W:0] exp_v;
        forever begin
            @(negedge clk);
            if (bus.done && !done_seen) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got cycle_cnt=%0d want no completion", bus.cycle_cnt);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("done_cycle_cnt", 64'(bus.cycle_cnt), 64'(exp_v[CNT_W-1:0]));
                    check("done_timeout", 64'(bus.timeout), 64'(exp_v[CNT_W]));
                end
            end
            done_seen = bus.done;
            if (bus.core_en) en_cnt++;
            if (bus.busy && bus.core_reset) rst_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
    endtask

    task automatic pulse_step();
        @(posedge clk); #1 bus.step = 1'b1;
        @(posedge clk); #1 bus.step = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, input string name);
        int n = 0;
        while (!bus.done && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        if (!bus.done) begin
            total++;
            bad++;
            $display("FAIL %s_wait: got done=0 after %0d cycles want done=1", name, n);
        end
    endtask

    // Free run from the current state; returns enabled/reset cycle deltas.
    task automatic run_and_check(input logic [PC_W-1:0] base, input logic [PC_W-1:0] inc,
                                 input logic [PC_W-1:0] hpc, input logic to,
                                 input int exp_cnt, input string name);
        int en0, rst0;
        pc_base     = base;
        pc_inc      = inc;
        bus.halt_pc = hpc;
        exp_q.push_back({to, CNT_W'(exp_cnt)});
        en0  = en_cnt;
        rst0 = rst_cnt;
        pulse_start();
        #1;
        check({name, "_cnt_cleared"}, 64'(bus.cycle_cnt), 64'd0);
        check({name, "_timeout_cleared"}, 64'(bus.timeout), 64'd0);
        wait_done(300, name);
        check({name, "_rst_cycles"}, 64'(rst_cnt - rst0), 64'(RST_CYCLES));
        check({name, "_en_cycles"}, 64'(en_cnt - en0), 64'(exp_cnt));
        @(negedge clk);
        check({name, "_en_low_after"}, 64'(bus.core_en), 64'd0);
        check({name, "_cnt_held"}, 64'(bus.cycle_cnt), 64'(exp_cnt));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int en0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.step_mode = 1'b0;
        bus.step      = 1'b0;
        bus.halt_pc   = 32'h3010;

        repeat (2) @(negedge clk);
        check("rst_core_reset", 64'(bus.core_reset), 64'd1);
        check("rst_core_en", 64'(bus.core_en), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_timeout", 64'(bus.timeout), 64'd0);
        check("rst_cycle_cnt", 64'(bus.cycle_cnt), 64'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_until_start", 64'(bus.dbg_state), 64'd0);

        // PC hits halt_pc on the 5th enabled cycle, then an identical restart.
        run_and_check(32'h3000, 32'd4, 32'h3010, 1'b0, 5, "halt_pc");
        run_and_check(32'h3000, 32'd4, 32'h3010, 1'b0, 5, "restart");
        // PC frozen: stable counter reaches 8 on the 9th enabled cycle.
        run_and_check(32'h3008, 32'd0, 32'h3010, 1'b0, 9, "stable");
        // Never matches: cycle limit ends the run.
        run_and_check(32'h3000, 32'd4, 32'hFFFF_FFFC, 1'b1, 100, "limit");
        // Match on the very cycle the limit is reached: not a timeout.
        run_and_check(32'h3000, 32'd4, 32'h3000 + 32'd396, 1'b0, 100, "limit_and_pc");

        // Single-step: step in DONE is ignored.
        @(posedge clk); #1 bus.step = 1'b1;
        @(negedge clk);
        check("step_ignored_in_done", 64'(bus.core_en), 64'd0);
        @(posedge clk); #1 bus.step = 1'b0;

        pc_base       = 32'h3000;
        pc_inc        = 32'd4;
        bus.halt_pc   = 32'h3024;
        bus.step_mode = 1'b1;
        en0 = en_cnt;
        pulse_start();
        repeat (8) @(posedge clk);
        #1;
        check("step_wait_state", 64'(bus.dbg_state), 64'd3);
        for (int i = 0; i < 3; i++) begin
            pulse_step();
            repeat (4) @(posedge clk);
        end
        #1;
        check("step_en_cycles", 64'(en_cnt - en0), 64'd3);
        check("step_cycle_cnt", 64'(bus.cycle_cnt), 64'd3);
        check("step_busy", 64'(bus.busy), 64'd1);
        check("step_done", 64'(bus.done), 64'd0);
        pulse_start();
        #1;
        check("start_ignored_step_cnt", 64'(bus.cycle_cnt), 64'd3);
        check("start_ignored_step_rst", 64'(bus.core_reset), 64'd0);
        // Leave single-step; the remaining 7 enabled cycles reach 0x3024.
        exp_q.push_back({1'b0, CNT_W'(10)});
        @(posedge clk); #1 bus.step_mode = 1'b0;
        wait_done(50, "step_to_run");

        // Reset asserted mid-run; a start during RUN must change nothing.
        pc_base     = 32'h3000;
        pc_inc      = 32'd4;
        bus.halt_pc = 32'hFFFF_FFFC;
        pulse_start();
        repeat (8) @(posedge clk);
        pulse_start();
        #1;
        check("start_ignored_run_state", 64'(bus.dbg_state), 64'd2);
        check("start_ignored_run_rst", 64'(bus.core_reset), 64'd0);
        n = 0;
        while (bus.cycle_cnt != 20 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reached_cnt_20", 64'(bus.cycle_cnt), 64'd20);
        rst_n = 1'b0;
        #1;
        check("async_state", 64'(bus.dbg_state), 64'd0);
        check("async_core_reset", 64'(bus.core_reset), 64'd1);
        check("async_core_en", 64'(bus.core_en), 64'd0);
        check("async_busy", 64'(bus.busy), 64'd0);
        check("async_done", 64'(bus.done), 64'd0);
        check("async_timeout", 64'(bus.timeout), 64'd0);
        check("async_cycle_cnt", 64'(bus.cycle_cnt), 64'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_reset_idle", 64'(bus.dbg_state), 64'd0);
        check("post_reset_busy", 64'(bus.busy), 64'd0);

        repeat (2) @(negedge clk);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
